mem_port_arbiter: RTL

Single-port arbiter between the instruction-fetch (IF) stage and the memory (MEM) stage of the pipelined CPU. Both stages share one unified 256 x 8 memory (`mem_inst`). The block issues at most one memory access per cycle, gives data accesses priority, and atomically sequences two-byte fetches (opcode + operand, e.g. LDD/STD/LDI). It sits between the stage logic and `mem_inst`, and drives the IF stall.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_starve_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the IF/MEM single-port memory arbiter.
//
// Contents:
//   arb_state_e : IDLE (arbitrate a new access) / LONG2 (second byte of a long fetch)
//   owner_e     : tag of the read in flight, used to route mem_rdata one cycle later
//   *_DEF       : default ADDR_W, DATA_W and STARVE_MAX
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 8;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        LONG2 = 1'b1
    } arb_state_e;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        DATA     = 3'd1,
        IF1      = 3'd2,
        IF1_LONG = 3'd3,
        IF2      = 3'd4
    } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Starvation guard for the memory arbiter: counts data grants issued while a
// fetch is waiting and flags when the fetch must be forced through.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc      : a data grant was issued while if_req was high
//   clr      : a fetch grant was issued
//   hit      : count has reached STARVE_MAX
module arb_starve_counter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] count_q;

    // Saturates at STARVE_MAX so a long-held hit cannot wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != CW'(STARVE_MAX))) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign hit = (count_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port arbiter between the IF stage and the MEM stage sharing one
// synchronous-read memory. One access per cycle, data has priority, and a
// two-byte (long) fetch is issued atomically over two consecutive cycles.
//
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX data grants
// with a fetch waiting, the next IDLE cycle grants the fetch instead.
//
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   if_req/if_addr/if_long           : fetch request (held until if_gnt; addr/long held through LONG2)
//   if_gnt, if_rdy, if_instr, if_imm : fetch accept, data-valid pulse, fetched bytes
//   dm_req/dm_we/dm_addr/dm_wdata    : data request (held until dm_gnt)
//   dm_gnt, dm_rdy, dm_rdata         : data accept, completion pulse, read data (0 after write)
//   stall_if                         : fetch requested but not granted this cycle
//   mem_addr/mem_we/mem_wdata        : memory command, combinational from the grant
//   mem_rdata                        : memory read data, valid the cycle after the address
//
// Handshake: a request is a level held until its gnt; gnt is combinational in
// the cycle the access is issued; rdy is a one-cycle pulse in the cycle the
// data is valid, and the data outputs hold until the next rdy on that port.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_long,
    output logic              if_gnt,
    output logic              if_rdy,
    output logic [DATA_W-1:0] if_instr,
    output logic [DATA_W-1:0] if_imm,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rdy,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_if,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              wr_q;
    logic [DATA_W-1:0] instr_q, imm_q, rdata_q;
    logic              starve_hit;

`ifdef ARB_STARVE_GUARD_EN
    // dm_gnt is only ever raised in IDLE, so no extra state qualifier needed.
    arb_starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (dm_gnt & if_req),
        .clr (if_gnt),
        .hit (starve_hit)
    );
`else
    // Strict data priority: the guard never fires.
    assign starve_hit = (STARVE_MAX < 0);
`endif

    // Arbitration and memory command. Everything stays at 0 while rst is high.
    always_comb begin
        state_d   = state_q;
        owner_d   = NONE;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (!rst) begin
            if (state_q == LONG2) begin
                // Second byte; wraps modulo 2^ADDR_W through natural truncation.
                mem_addr = if_addr + ADDR_W'(1);
                owner_d  = IF2;
                state_d  = IDLE;
            end else if (if_req && (starve_hit || !dm_req)) begin
                if_gnt   = 1'b1;
                mem_addr = if_addr;
                if (if_long) begin
                    owner_d = IF1_LONG;
                    state_d = LONG2;
                end else begin
                    owner_d = IF1;
                end
            end else if (dm_req) begin
                dm_gnt   = 1'b1;
                mem_addr = dm_addr;
                mem_we   = dm_we;
                owner_d  = DATA;
                if (dm_we) begin
                    mem_wdata = dm_wdata;
                end
            end
        end
    end

    assign stall_if = if_req & ~if_gnt & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= NONE;
            wr_q    <= 1'b0;
            instr_q <= '0;
            imm_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= dm_gnt & dm_we;
            // Capture the routed byte so the port outputs hold until the next rdy.
            case (owner_q)
                DATA:     rdata_q <= dm_rdata;
                IF1: begin
                    instr_q <= mem_rdata;
                    imm_q   <= '0;
                end
                IF1_LONG: instr_q <= mem_rdata;
                IF2:      imm_q   <= mem_rdata;
                default:  ;
            endcase
        end
    end

    // Response routing: the owner tag of last cycle's access selects who
    // sees mem_rdata now. A long fetch's opcode was parked in instr_q.
    assign if_rdy   = (owner_q == IF1) || (owner_q == IF2);
    assign dm_rdy   = (owner_q == DATA);
    assign if_instr = (owner_q == IF1) ? mem_rdata : instr_q;
    assign if_imm   = (owner_q == IF2) ? mem_rdata :
                      (owner_q == IF1) ? '0 : imm_q;
    assign dm_rdata = (owner_q != DATA) ? rdata_q :
                      (wr_q ? '0 : mem_rdata);

endmodule
